// File: rtl/silife_pkg.sv
// Shared silife definitions: dump FSM states, segment and row address widths.
// SEG_BROADCAST is common to the grid loader and the grid dumper.
package silife_pkg;

    localparam int SEG_BITS      = 15;
    localparam int ROW_ADDR_BITS = 16;

    localparam logic [SEG_BITS-1:0] SEG_BROADCAST = 15'h7fff;

    typedef enum logic [2:0] {
        DumpIdle,
        DumpSegAddr,
        DumpRowAddr,
        DumpFetch,
        DumpData
    } dump_state_e;

endpackage

// File: rtl/silife_grid_dumper_if.sv
// Serial dump pin set: host drives cs/clk/data and the upstream chain,
// the segment drives the miso output towards the host.
interface silife_grid_dumper_if;

    logic i_dump_cs;
    logic i_dump_clk;
    logic i_dump_data;
    logic i_dump_chain;
    logic o_dump_data;

    modport master (
        output i_dump_cs, i_dump_clk, i_dump_data, i_dump_chain,
        input  o_dump_data
    );

    modport slave (
        input  i_dump_cs, i_dump_clk, i_dump_data, i_dump_chain,
        output o_dump_data
    );

endinterface

// File: rtl/silife_buf_reg.sv
// Two-flop synchroniser for an asynchronous input.
// DEFAULT is the value presented while reset is held.
module silife_buf_reg #(
    parameter bit DEFAULT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q, sync_d;

    // shift the async input through two capture stages
    always_comb sync_d = {sync_q[0], d};

    // capture register
    always_ff @(posedge clk) begin
        if (reset) sync_q <= {2{DEFAULT}};
        else       sync_q <= sync_d;
    end

    assign q = sync_q[1];

endmodule

// File: rtl/silife_row_shifter.sv
// Snapshot shift register for one grid row, MSB (cell WIDTH-1) out first.
// SILIFE_DUMP_PARITY_EN: even parity of the snapshot follows cell 0.
module silife_row_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] word,
    output logic             msb
);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic             fill;

`ifdef SILIFE_DUMP_PARITY_EN
    logic parity_q, parity_d;

    // parity of the snapshot is shifted in behind the cells
    always_comb begin
        parity_d = parity_q;
        if (clear)     parity_d = 1'b0;
        else if (load) parity_d = ^word;
    end

    // parity register
    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end

    assign fill = parity_q;
`else
    assign fill = 1'b0;
`endif

    // load a row snapshot or shift it towards the output
    always_comb begin
        shift_d = shift_q;
        if (clear)      shift_d = '0;
        else if (load)  shift_d = word;
        else if (shift) shift_d = {shift_q[WIDTH-2:0], fill};
    end

    // shift register
    always_ff @(posedge clk) begin
        if (reset) shift_q <= '0;
        else       shift_q <= shift_d;
    end

    assign msb = shift_q[WIDTH-1];

endmodule

// File: rtl/silife_grid_dumper.sv
// Grid read-back: address frame in, row-by-row cell stream out on miso.
// SILIFE_DUMP_PARITY_EN appends an even-parity bit to every row.
module silife_grid_dumper
    import silife_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int HEIGHT   = 32,
    localparam int ROW_BITS = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                reset,
    silife_grid_dumper_if.slave dump,
    input  logic [SEG_BITS-1:0] i_local_address,
    output logic [ROW_BITS-1:0] o_row_select,
    input  logic [WIDTH-1:0]    i_row_cells,
    output logic                o_selected
);

    localparam int CNT_BITS = $clog2(WIDTH + ROW_ADDR_BITS);
`ifdef SILIFE_DUMP_PARITY_EN
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WIDTH);
`else
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WIDTH - 1);
`endif

    logic cs_s, clk_s, data_s, rise, msb, load, shift;
    logic clk_past_q, clk_past_d;

    dump_state_e         state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [SEG_BITS-1:0] seg_q, seg_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [ROW_BITS-1:0] row_sel_q, row_sel_d;

    silife_buf_reg #(.DEFAULT(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(dump.i_dump_cs), .q(cs_s));
    silife_buf_reg #(.DEFAULT(1'b0)) u_sync_clk (
        .clk(clk), .reset(reset), .d(dump.i_dump_clk), .q(clk_s));
    silife_buf_reg #(.DEFAULT(1'b0)) u_sync_data (
        .clk(clk), .reset(reset), .d(dump.i_dump_data), .q(data_s));

    silife_row_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk(clk), .reset(reset), .clear(cs_s), .load(load),
        .shift(shift), .word(i_row_cells), .msb(msb));

    assign clk_past_d = clk_s;
    assign rise       = clk_s & ~clk_past_q;

    // frame sequencing: address capture, row fetch, bit streaming
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seg_d     = seg_q;
        row_d     = row_q;
        row_sel_d = row_sel_q;
        load      = 1'b0;
        shift     = 1'b0;
        if (cs_s) begin
            state_d   = DumpIdle;
            cnt_d     = '0;
            seg_d     = '0;
            row_d     = '0;
            row_sel_d = '0;
        end else begin
            unique case (state_q)
                DumpIdle: begin
                    state_d = DumpSegAddr;
                    cnt_d   = CNT_BITS'(SEG_BITS - 1);
                end
                DumpSegAddr: if (rise) begin
                    seg_d[cnt_q[3:0]] = data_s;
                    if (cnt_q == '0) begin
                        state_d = DumpRowAddr;
                        cnt_d   = CNT_BITS'(ROW_ADDR_BITS - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_BITS'(1);
                    end
                end
                DumpRowAddr: if (rise) begin
                    for (int i = 0; i < ROW_BITS; i++)
                        if (int'(cnt_q) == ROW_ADDR_BITS - 1 - i)
                            row_d[i] = data_s;
                    if (cnt_q == '0) state_d = DumpFetch;
                    else             cnt_d   = cnt_q - CNT_BITS'(1);
                end
                DumpFetch: begin
                    // first cycle presents the row, second takes the snapshot
                    if (cnt_q == '0) begin
                        row_sel_d = row_q;
                        cnt_d     = CNT_BITS'(1);
                    end else begin
                        load    = 1'b1;
                        cnt_d   = LAST_BIT;
                        state_d = DumpData;
                    end
                end
                DumpData: if (rise) begin
                    if (cnt_q == '0) begin
                        row_d   = row_q + ROW_BITS'(1);
                        state_d = DumpFetch;
                    end else begin
                        shift = 1'b1;
                        cnt_d = cnt_q - CNT_BITS'(1);
                    end
                end
                default: state_d = DumpIdle;
            endcase
        end
    end

    // state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DumpIdle;
            cnt_q      <= '0;
            seg_q      <= '0;
            row_q      <= '0;
            row_sel_q  <= '0;
            clk_past_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_q      <= seg_d;
            row_q      <= row_d;
            row_sel_q  <= row_sel_d;
            clk_past_q <= clk_past_d;
        end
    end

    // broadcast address never reads, so two segments never fight the bus
    assign o_selected = (seg_q == i_local_address) && (seg_q != SEG_BROADCAST)
                        && (state_q == DumpData);
    assign o_row_select     = row_sel_q;
    assign dump.o_dump_data = o_selected ? msb : dump.i_dump_chain;

endmodule
